// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared state encoding for the bit-serial adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

   // Width of the controller state register
   localparam int SA_STATE_W = 2;

   typedef enum logic [SA_STATE_W-1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sa_state_t;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : Single-bit full adder cell driven one bit per clock by
//                serial_adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
   input  logic A,
   input  logic B,
   input  logic C,
   output logic sum,
   output logic carry
);

   assign sum   = A ^ B ^ C;
   assign carry = (A & B) | (C & (A ^ B));

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial WIDTH-bit adder. Latches operands on start and
//                feeds them LSB-first through one full_adder cell, one bit
//                per clock, with a registered carry between bits.
//                Optional subtract mode: define SERIAL_ADDER_SUB_EN to add
//                the sub port (a - b, cout = no-borrow).
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int                 CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

   sa_state_t        state_q, state_d;
   logic [WIDTH-1:0] a_sh_q,  a_sh_d;
   logic [WIDTH-1:0] b_sh_q,  b_sh_d;
   logic [WIDTH-1:0] res_q,   res_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] sum_q,   sum_d;
   logic             cout_q,  cout_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;

   logic             fa_sum;
   logic             fa_carry;
   logic [WIDTH-1:0] res_next;

   // Operand B and carry-in as they are loaded; subtract mode uses ~b + 1
   logic [WIDTH-1:0] b_load;
   logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
   assign b_load     = sub ? ~b   : b;
   assign carry_load = sub ? 1'b1 : cin;
`else
   assign b_load     = b;
   assign carry_load = cin;
`endif

   full_adder u_full_adder (
      .A     (a_sh_q[0]),
      .B     (b_sh_q[0]),
      .C     (carry_q),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   // New sum bit enters at the MSB so the LSB-first stream lands in order
   if (WIDTH == 1) begin : g_res_w1
      assign res_next = fa_sum;
   end else begin : g_res_wn
      assign res_next = {fa_sum, res_q[WIDTH-1:1]};
   end

   // Next-state and datapath update for the serial controller
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b_load;
               carry_d = carry_load;
               cnt_d   = '0;
               res_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            res_d   = res_next;
            carry_d = fa_carry;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               // Publish only complete results
               sum_d   = res_next;
               cout_d  = fa_carry;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and datapath registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Directed and random self-checking bench for serial_adder
//                at WIDTH=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] prev_sum  = '0;
   logic         prev_cout = 1'b0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one operation starting at posedge+1. pulse_k>0 re-pulses start
   // (with junk operands) so that it is sampled at edge E(pulse_k).
   task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic tsub,
                        input logic [W-1:0] exp_s, input logic exp_c, input int pulse_k);
      start = 1'b1; a = ta; b = tb; cin = tcin; sub = tsub;
      @(posedge clk); #1;                       // E0
      start = 1'b0;
      a = ~ta; b = ~tb; cin = ~tcin;            // later input changes must not matter
      for (int k = 1; k <= W + 1; k++) begin
         if (k == pulse_k) begin
            start = 1'b1; a = 8'h11; b = 8'h22;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         chk({tag, "_busy"}, busy, (k <= W) ? 1 : 0);
         chk({tag, "_done"}, done, (k == W) ? 1 : 0);
         chk({tag, "_sum"},  sum,  (k >= W) ? exp_s : prev_sum);
         chk({tag, "_cout"}, cout, (k >= W) ? exp_c : prev_cout);
      end
      start     = 1'b0;
      prev_sum  = exp_s;
      prev_cout = exp_c;
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [W:0]   full;
      int           dcount;

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum",  sum,  0);
      chk("rst_cout", cout, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: zero operands, full latency/pulse profile
      do_op("t1", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 0);
      // 2: wrap with carry-out, then carry-in path with held previous result
      do_op("t2a", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 0);
      do_op("t2b", 8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0, 0);
      // 3: start re-pulsed during the 3rd RUN cycle, and again during DONE
      do_op("t3", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 3);
      do_op("t3d", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, W + 1);
      do_op("t3e", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 0);

      // 4: reset after the 4th RUN edge
      start = 1'b1; a = 8'hAA; b = 8'h11; cin = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t4_busy", busy, 0);
      chk("t4_done", done, 0);
      chk("t4_sum",  sum,  0);
      chk("t4_cout", cout, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      dcount = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (done) dcount++;
      end
      chk("t4_nodone", dcount, 0);
      chk("t4_idle",   busy,   0);
      prev_sum = '0; prev_cout = 1'b0;
      do_op("t4b", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
      // 5: subtract mode ignores cin
      do_op("t5a", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 0);
      do_op("t5b", 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 0);
`endif

      // 6: random back-to-back sweep at the earliest legal start edge
      for (int n = 0; n < 1000; n++) begin
         ra = W'($urandom_range(0, 255));
         rb = W'($urandom_range(0, 255));
         rc = 1'($urandom_range(0, 1));
         full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         do_op("rnd", ra, rb, rc, 1'b0, full[W-1:0], full[W], 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_serial_adder
`default_nettype wire
